// File: rtl/ram_load_ctrl.sv
// ram_load_ctrl
// Write-side front end for a single-port synchronous RAM. Three write sources
// share one registered write port, and at most one write is issued per clock:
//   - power-on clear sweep (only with RAM_LOAD_CLEAR_EN defined)
//   - download stream, buffered in a small FIFO
//   - CPU write strobe, captured in a one-entry holding register
// In RUN the FIFO has priority over the CPU. A starvation counter forces the
// pending CPU write out after CPU_SLOT consecutive FIFO writes.
//
// Optional feature macro: RAM_LOAD_CLEAR_EN (adds the CLEAR state and sweep counter)
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   dl_valid/dl_ready            download beat handshake
//   dl_addr/dl_data              download beat payload
//   dl_done                      pulse: download stream ended
//   cpu_we/cpu_addr/cpu_din      CPU write strobe and payload
//   cpu_busy                     strobes ignored while high
//   ram_address/ram_nwe/ram_din  registered RAM write port (nwe active-low)
//   clearing                     clear sweep in progress
//   load_done                    every download write has been issued
module ram_load_ctrl #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ADDR_BITS = 11,
   parameter int unsigned FIFO_LOG2 = 2,
   parameter int unsigned CPU_SLOT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 dl_valid,
   output logic                 dl_ready,
   input  logic [ADDR_BITS-1:0] dl_addr,
   input  logic [DATA_BITS-1:0] dl_data,
   input  logic                 dl_done,
   input  logic                 cpu_we,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [DATA_BITS-1:0] cpu_din,
   output logic                 cpu_busy,
   output logic [ADDR_BITS-1:0] ram_address,
   output logic                 ram_nwe,
   output logic [DATA_BITS-1:0] ram_din,
   output logic                 clearing,
   output logic                 load_done
);

   localparam int unsigned DEPTH = 1 << FIFO_LOG2;
   localparam int unsigned PW    = FIFO_LOG2;
   localparam int unsigned CW    = FIFO_LOG2 + 1;
   localparam int unsigned SW    = $clog2(CPU_SLOT + 1);
   localparam logic [CW-1:0] CNT_FULL = {1'b1, {PW{1'b0}}};
   localparam logic [SW-1:0] SLOT_MAX = SW'(CPU_SLOT);

   logic [ADDR_BITS-1:0] fifo_addr_q [DEPTH];
   logic [DATA_BITS-1:0] fifo_data_q [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 dl_ready_q, dl_ready_d;
   logic                 cpu_full_q, cpu_full_d;
   logic                 cpu_busy_q, cpu_busy_d;
   logic [ADDR_BITS-1:0] cpu_addr_q, cpu_addr_d;
   logic [DATA_BITS-1:0] cpu_din_q, cpu_din_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic                 done_seen_q, done_seen_d;
   logic                 load_done_q, load_done_d;
   logic [ADDR_BITS-1:0] ram_address_q, ram_address_d;
   logic                 ram_nwe_q, ram_nwe_d;
   logic [DATA_BITS-1:0] ram_din_q, ram_din_d;
   logic                 push, pop_fifo, issue_cpu, cpu_load, in_clear;

`ifdef RAM_LOAD_CLEAR_EN
   typedef enum logic {S_CLEAR, S_RUN} state_e;
   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] sweep_q, sweep_d;
   logic                 clearing_q;
   assign in_clear = (state_q == S_CLEAR);
   assign clearing = clearing_q;
`else
   assign in_clear = 1'b0;
   assign clearing = 1'b0;
`endif

   assign dl_ready    = dl_ready_q;
   assign cpu_busy    = cpu_busy_q;
   assign ram_address = ram_address_q;
   assign ram_nwe     = ram_nwe_q;
   assign ram_din     = ram_din_q;
   assign load_done   = load_done_q;

   always_comb begin
      // Handshakes use the registered ready/busy, so the FIFO can never overflow
      // and the holding register is never loaded while it is still full.
      push      = dl_valid && dl_ready_q;
      cpu_load  = cpu_we && !cpu_busy_q;
      pop_fifo  = !in_clear && (count_q != '0) && (starve_q < SLOT_MAX);
      issue_cpu = !in_clear && !pop_fifo && cpu_full_q;

      ram_nwe_d     = 1'b1;
      ram_address_d = ram_address_q;
      ram_din_d     = ram_din_q;

`ifdef RAM_LOAD_CLEAR_EN
      state_d = state_q;
      sweep_d = sweep_q;
      if (in_clear) begin
         ram_nwe_d     = 1'b0;
         ram_address_d = sweep_q;
         ram_din_d     = '0;
         sweep_d       = sweep_q + ADDR_BITS'(1);
         if (&sweep_q) state_d = S_RUN;
      end
`endif

      if (pop_fifo) begin
         ram_nwe_d     = 1'b0;
         ram_address_d = fifo_addr_q[rd_ptr_q];
         ram_din_d     = fifo_data_q[rd_ptr_q];
      end else if (issue_cpu) begin
         ram_nwe_d     = 1'b0;
         ram_address_d = cpu_addr_q;
         ram_din_d     = cpu_din_q;
      end

      rd_ptr_d = pop_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push     ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d  = count_q;
      if (push && !pop_fifo)      count_d = count_q + CW'(1);
      else if (!push && pop_fifo) count_d = count_q - CW'(1);

      // Only FIFO writes made while a CPU write waits count towards starvation.
      starve_d = starve_q;
      if (issue_cpu || !cpu_full_q) starve_d = '0;
      else if (pop_fifo)            starve_d = starve_q + SW'(1);

      cpu_full_d = cpu_full_q;
      cpu_addr_d = cpu_addr_q;
      cpu_din_d  = cpu_din_q;
      if (issue_cpu) cpu_full_d = 1'b0;
      if (cpu_load) begin
         cpu_full_d = 1'b1;
         cpu_addr_d = cpu_addr;
         cpu_din_d  = cpu_din;
      end

      // A beat accepted together with dl_done is the final beat; any other
      // accepted beat reopens the download. Completion needs an empty FIFO
      // one cycle after the last pop.
      load_done_d = push ? 1'b0 : (load_done_q || (done_seen_q && (count_q == '0)));
      done_seen_d = push ? dl_done : (done_seen_q || dl_done);

      dl_ready_d = !in_clear && (count_d != CNT_FULL);
      cpu_busy_d = cpu_full_d || in_clear;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         dl_ready_q    <= 1'b0;
         cpu_full_q    <= 1'b0;
         cpu_busy_q    <= 1'b1;
         cpu_addr_q    <= '0;
         cpu_din_q     <= '0;
         starve_q      <= '0;
         done_seen_q   <= 1'b0;
         load_done_q   <= 1'b0;
         ram_address_q <= '0;
         ram_nwe_q     <= 1'b1;
         ram_din_q     <= '0;
`ifdef RAM_LOAD_CLEAR_EN
         state_q       <= S_CLEAR;
         sweep_q       <= '0;
         clearing_q    <= 1'b1;
`endif
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         dl_ready_q    <= dl_ready_d;
         cpu_full_q    <= cpu_full_d;
         cpu_busy_q    <= cpu_busy_d;
         cpu_addr_q    <= cpu_addr_d;
         cpu_din_q     <= cpu_din_d;
         starve_q      <= starve_d;
         done_seen_q   <= done_seen_d;
         load_done_q   <= load_done_d;
         ram_address_q <= ram_address_d;
         ram_nwe_q     <= ram_nwe_d;
         ram_din_q     <= ram_din_d;
`ifdef RAM_LOAD_CLEAR_EN
         state_q       <= state_d;
         sweep_q       <= sweep_d;
         clearing_q    <= in_clear;
`endif
      end
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= dl_addr;
         fifo_data_q[wr_ptr_q] <= dl_data;
      end
   end

endmodule
